a_pattern_driver: RTL and testbench

- Drives the single-bit level input A of the fsm block (the A-input/K1-K2-output control FSM) from a programmable run-length segment table.
- Counts the K1 and K2 responses that the fsm block returns during a run.
- Sits on the fsm's input side as the in-system counterpart to the fsm: a programmable A source plus a K1/K2 response counter, usable on-chip and in bring-up benches.

---
 rtl/a_pattern_driver_if.sv | 33 +++
 rtl/a_pattern_driver.sv | 145 ++++++++++++++
 tb/tb_a_pattern_driver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/a_pattern_driver_if.sv
// Bus bundle between a_pattern_driver and its controller: segment table writes,
// run control, fsm K1/K2 responses, and the A drive and status outputs.
interface a_pattern_driver_if #(
  parameter int SEG_NUM = 8,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16
);
  localparam int AW = $clog2(SEG_NUM);

  logic             seg_we;
  logic [AW-1:0]    seg_addr;
  logic             seg_level;
  logic [LEN_W-1:0] seg_len;
  logic             start;
  logic             abort;
  logic             k1_in;
  logic             k2_in;
  logic             a_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] k1_cnt;
  logic [CNT_W-1:0] k2_cnt;

  modport master (
    output seg_we, seg_addr, seg_level, seg_len, start, abort, k1_in, k2_in,
    input  a_out, busy, done, k1_cnt, k2_cnt
  );

  modport slave (
    input  seg_we, seg_addr, seg_level, seg_len, start, abort, k1_in, k2_in,
    output a_out, busy, done, k1_cnt, k2_cnt
  );
endinterface

// File: rtl/a_pattern_driver.sv
// Programmable run-length A source for the fsm block, with saturating counters
// for the K1/K2 rising edges the fsm returns while a run is active.
module a_pattern_driver #(
  parameter int   SEG_NUM    = 8,
  parameter int   LEN_W      = 16,
  parameter int   CNT_W      = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  a_pattern_driver_if.slave bus
);
  localparam int AW = $clog2(SEG_NUM);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d, idx_nxt;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic             a_out_q, a_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] k1_cnt_q, k1_cnt_d;
  logic [CNT_W-1:0] k2_cnt_q, k2_cnt_d;
  logic             k1_prev_q, k1_prev_d;
  logic             k2_prev_q, k2_prev_d;
  logic             lvl_q [SEG_NUM];
  logic             lvl_d [SEG_NUM];
  logic [LEN_W-1:0] len_q [SEG_NUM];
  logic [LEN_W-1:0] len_d [SEG_NUM];
  logic             last_seg;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_cnt_d = len_cnt_q;
    a_out_d   = a_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    k1_cnt_d  = k1_cnt_q;
    k2_cnt_d  = k2_cnt_q;
    k1_prev_d = bus.k1_in;
    k2_prev_d = bus.k2_in;
    lvl_d     = lvl_q;
    len_d     = len_q;
    idx_nxt   = idx_q + AW'(1);
    last_seg  = (idx_q == AW'(SEG_NUM - 1)) || (len_q[idx_nxt] == '0);

    // The table is frozen while a run is in progress
    if (bus.seg_we && !busy_q) begin
      lvl_d[bus.seg_addr] = bus.seg_level;
      len_d[bus.seg_addr] = bus.seg_len;
    end

    if (busy_q) begin
      if (bus.k1_in && !k1_prev_q && (k1_cnt_q != '1)) k1_cnt_d = k1_cnt_q + CNT_W'(1);
      if (bus.k2_in && !k2_prev_q && (k2_cnt_q != '1)) k2_cnt_d = k2_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          k1_cnt_d = '0;
          k2_cnt_d = '0;
          if (len_q[0] == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = RUN;
            idx_d     = '0;
            len_cnt_d = len_q[0] - LEN_W'(1);
            a_out_d   = lvl_q[0];
            busy_d    = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          a_out_d = IDLE_LEVEL;
          busy_d  = 1'b0;
        end else if (len_cnt_q == '0) begin
          if (last_seg) begin
            state_d = DONE;
            a_out_d = IDLE_LEVEL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_nxt;
            len_cnt_d = len_q[idx_nxt] - LEN_W'(1);
            a_out_d   = lvl_q[idx_nxt];
          end
        end else begin
          len_cnt_d = len_cnt_q - LEN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        a_out_d = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_cnt_q <= '0;
      a_out_q   <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      k1_cnt_q  <= '0;
      k2_cnt_q  <= '0;
      k1_prev_q <= 1'b0;
      k2_prev_q <= 1'b0;
      for (int i = 0; i < SEG_NUM; i++) begin
        lvl_q[i] <= 1'b0;
        len_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_cnt_q <= len_cnt_d;
      a_out_q   <= a_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      k1_cnt_q  <= k1_cnt_d;
      k2_cnt_q  <= k2_cnt_d;
      k1_prev_q <= k1_prev_d;
      k2_prev_q <= k2_prev_d;
      lvl_q     <= lvl_d;
      len_q     <= len_d;
    end
  end

  assign bus.a_out  = a_out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.k1_cnt = k1_cnt_q;
  assign bus.k2_cnt = k2_cnt_q;
endmodule

// File: tb/tb_a_pattern_driver.sv
// Directed bench for a_pattern_driver: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus, used to check counter saturation.
module tb_a_pattern_driver;
  localparam int SEG_NUM = 8;
  localparam int LEN_W   = 16;
  localparam int AW      = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             seg_we = 1'b0;
  logic [AW-1:0]    seg_addr = '0;
  logic             seg_level = 1'b0;
  logic [LEN_W-1:0] seg_len = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             k1_in = 1'b0;
  logic             k2_in = 1'b0;
  int               checks = 0;
  int               failures = 0;
  int               busy_cnt = 0;
  logic             exp_a;

  a_pattern_driver_if #(.SEG_NUM(SEG_NUM), .LEN_W(LEN_W), .CNT_W(16)) bus_a ();
  a_pattern_driver_if #(.SEG_NUM(SEG_NUM), .LEN_W(LEN_W), .CNT_W(2))  bus_b ();

  assign bus_a.seg_we = seg_we;    assign bus_b.seg_we = seg_we;
  assign bus_a.seg_addr = seg_addr;  assign bus_b.seg_addr = seg_addr;
  assign bus_a.seg_level = seg_level; assign bus_b.seg_level = seg_level;
  assign bus_a.seg_len = seg_len;   assign bus_b.seg_len = seg_len;
  assign bus_a.start = start;     assign bus_b.start = start;
  assign bus_a.abort = abort;     assign bus_b.abort = abort;
  assign bus_a.k1_in = k1_in;     assign bus_b.k1_in = k1_in;
  assign bus_a.k2_in = k2_in;     assign bus_b.k2_in = k2_in;

  a_pattern_driver #(.SEG_NUM(SEG_NUM), .LEN_W(LEN_W), .CNT_W(16), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  a_pattern_driver #(.SEG_NUM(SEG_NUM), .LEN_W(LEN_W), .CNT_W(2), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic ea, input logic eb, input logic ed);
    checkOutput({tag, ".a_out"}, 32'(bus_a.a_out), 32'(ea));
    checkOutput({tag, ".busy"},  32'(bus_a.busy),  32'(eb));
    checkOutput({tag, ".done"},  32'(bus_a.done),  32'(ed));
  endtask

  task automatic checkCounts(input string tag, input int e1a, input int e2a, input int e1b, input int e2b);
    checkOutput({tag, ".k1a"}, 32'(bus_a.k1_cnt), 32'(e1a));
    checkOutput({tag, ".k2a"}, 32'(bus_a.k2_cnt), 32'(e2a));
    checkOutput({tag, ".k1b"}, 32'(bus_b.k1_cnt), 32'(e1b));
    checkOutput({tag, ".k2b"}, 32'(bus_b.k2_cnt), 32'(e2b));
  endtask

  task automatic applyStimulus(input int addr, input logic lvl, input int len);
    seg_we    = 1'b1;
    seg_addr  = AW'(addr);
    seg_level = lvl;
    seg_len   = LEN_W'(len);
    @(negedge clk);
    seg_we = 1'b0;
  endtask

  // Leaves the caller in the first cycle after the edge that accepted start
  task automatic startRun();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkState("reset", 1'b0, 1'b0, 1'b0);
    checkCounts("reset", 0, 0, 0, 0);

    // Empty table: done only
    startRun();
    checkState("empty.c1", 1'b0, 1'b0, 1'b1);
    checkCounts("empty.c1", 0, 0, 0, 0);
    @(negedge clk);
    checkState("empty.c2", 1'b0, 1'b0, 1'b0);

    // Six-segment run totalling 1024 busy cycles
    applyStimulus(0, 1'b0, 50);
    applyStimulus(1, 1'b1, 150);
    applyStimulus(2, 1'b0, 500);
    applyStimulus(3, 1'b1, 100);
    applyStimulus(4, 1'b0, 100);
    applyStimulus(5, 1'b1, 124);
    applyStimulus(6, 1'b0, 0);
    startRun();
    busy_cnt = 0;
    for (int c = 1; c <= 1026; c++) begin
      exp_a = (c <= 50) ? 1'b0 : (c <= 200) ? 1'b1 : (c <= 700) ? 1'b0 :
              (c <= 800) ? 1'b1 : (c <= 900) ? 1'b0 : (c <= 1024) ? 1'b1 : 1'b0;
      checkState($sformatf("run1.c%0d", c), exp_a, c <= 1024, c == 1025);
      if (bus_a.busy) busy_cnt++;
      @(negedge clk);
    end
    checkOutput("run1.busy_cycles", 32'(busy_cnt), 32'd1024);
    checkCounts("run1.end", 0, 0, 0, 0);

    // Abort at busy cycle 10, then abort exactly on a segment boundary
    startRun();
    for (int c = 1; c <= 10; c++) begin
      checkState($sformatf("abort1.c%0d", c), 1'b0, 1'b1, 1'b0);
      if (c == 10) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int c = 11; c <= 14; c++) begin
      checkState($sformatf("abort1.c%0d", c), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    startRun();
    for (int c = 1; c <= 50; c++) begin
      if (c == 1 || c == 50) checkState($sformatf("abort2.c%0d", c), 1'b0, 1'b1, 1'b0);
      if (c == 50) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    checkState("abort2.c51", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkState("abort2.c52", 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkState("abort_idle", 1'b0, 1'b0, 1'b0);

    // K1/K2 edge counting, including the ending cycle and saturation
    applyStimulus(0, 1'b1, 40);
    applyStimulus(1, 1'b0, 0);
    startRun();
    for (int c = 1; c <= 43; c++) begin
      if (c == 1 || c == 40) checkState($sformatf("cnt.c%0d", c), 1'b1, 1'b1, 1'b0);
      if (c == 12) checkCounts("cnt.c12", 2, 0, 2, 0);
      if (c == 41) begin
        checkState("cnt.c41", 1'b0, 1'b0, 1'b1);
        checkCounts("cnt.c41", 5, 1, 3, 1);
      end
      if (c == 43) checkCounts("cnt.c43", 5, 1, 3, 1);
      k1_in = (c == 5 || c == 10 || c == 15 || c == 20 || c == 40 || c == 42);
      k2_in = (c >= 20 && c <= 39);
      @(negedge clk);
    end
    k1_in = 1'b0;
    k2_in = 1'b0;

    // Table write during a run is ignored
    startRun();
    for (int c = 1; c <= 42; c++) begin
      seg_we    = (c == 5);
      seg_addr  = '0;
      seg_level = 1'b0;
      seg_len   = LEN_W'(7);
      if (c == 10 || c == 40) checkState($sformatf("frz.c%0d", c), 1'b1, 1'b1, 1'b0);
      if (c == 41) checkState("frz.c41", 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    seg_we = 1'b0;
    startRun();
    checkState("frz2.c1", 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      if (c == 10) checkCounts("frz2.c10", 1, 0, 1, 0);
      k1_in = (c == 5);
      @(negedge clk);
    end
    k1_in = 1'b0;
    rst = 1'b1;
    #1;
    checkState("midrst", 1'b0, 1'b0, 1'b0);
    checkCounts("midrst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    startRun();
    checkState("postrst.c1", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkState("postrst.c2", 1'b0, 1'b0, 1'b0);

    // Full table without terminator; start in RUN and DONE is ignored
    for (int i = 0; i < SEG_NUM; i++) applyStimulus(i, (i % 2) == 0, 3);
    startRun();
    for (int c = 1; c <= 26; c++) begin
      exp_a = (c <= 24) ? (((c - 1) / 3) % 2 == 0) : 1'b0;
      checkState($sformatf("full.c%0d", c), exp_a, c <= 24, c == 25);
      start = (c == 10 || c == 25);
      @(negedge clk);
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
